// File: rtl/mem_layout_pkg.sv
// Shared type definitions for the DAC interface path.
// dac_mode_t      : generator mode carried by PS commands and reported on cur_mode.
// dac_seq_state_t : dac_mode_sequencer FSM state, exported on seq_state for the ILA.
package mem_layout_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_TRIG  = 2'b10,
    MODE_PWL   = 2'b11
  } dac_mode_t;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_RESET_GEN = 3'd1,
    SEQ_WAIT_RDY  = 3'd2,
    SEQ_RUN       = 3'd3,
    SEQ_DRAIN     = 3'd4
  } dac_seq_state_t;

endpackage

// File: rtl/dac_mode_sequencer.sv
// dac_mode_sequencer
// Moves sample_gen between modes on dac_clk. A new mode is entered by draining
// the in-flight batch pipeline, pulsing gen_rst, waiting for dac0_rdy and then
// raising exactly one run_* enable.
// Ports:
//   dac_clk, dac_rstn           clock, asynchronous active-low reset
//   cmd_mode/cmd_valid/cmd_ready mode command handshake (00 idle,01 shift,10 trig,11 pwl)
//   halt                        level, stops the generator, beats commands
//   dac0_rdy                    DAC tile ready
//   pwl_loaded                  PWL table holds a complete waveform
//   gen_batch_valid             sample_gen output valid (pipeline occupancy)
//   err_clear                   pulse, clears sticky errors
//   run_shift_regs/run_trig_wav/run_pwl  generator enables (one-hot or zero)
//   gen_rst                     synchronous reset to sample_gen
//   cur_mode                    running mode, 00 unless in RUN
//   seq_state                   FSM state for debug
//   err_pwl_empty, err_timeout  sticky error flags
module dac_mode_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic       dac_clk,
  input  logic       dac_rstn,
  input  logic [1:0] cmd_mode,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       halt,
  input  logic       dac0_rdy,
  input  logic       pwl_loaded,
  input  logic       gen_batch_valid,
  input  logic       err_clear,
  output logic       run_shift_regs,
  output logic       run_trig_wav,
  output logic       run_pwl,
  output logic       gen_rst,
  output logic [1:0] cur_mode,
  output logic [2:0] seq_state,
  output logic       err_pwl_empty,
  output logic       err_timeout
);
  import mem_layout_pkg::*;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(DRAIN_CYCLES - 1);

  dac_seq_state_t state_q, state_d;
  dac_mode_t      target_q, target_d;
  logic [CW-1:0]  timer_q, timer_d;
  logic [CW-1:0]  quiet_q, quiet_d;
  logic [2:0]     run_q, run_d;
  logic           gen_rst_q, gen_rst_d;
  dac_mode_t      cur_mode_q, cur_mode_d;
  logic           ready_q, ready_d;
  logic           err_pwl_q, err_pwl_d;
  logic           err_to_q, err_to_d;

  logic           accept;
  logic           pwl_set;
  logic           to_set;
  dac_mode_t      cmd_m;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // cmd_ready is registered, so it can still read 1 in the first cycle halt
  // rises; gating acceptance with the live halt keeps halt's priority.
  assign accept = cmd_valid & ready_q & ~halt;
  assign cmd_m  = dac_mode_t'(cmd_mode);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    timer_d  = sat_inc(timer_q);
    quiet_d  = quiet_q;
    pwl_set  = 1'b0;
    to_set   = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        timer_d = '0;
        if (accept && cmd_m != MODE_IDLE) begin
          if (cmd_m == MODE_PWL && !pwl_loaded) begin
            pwl_set = 1'b1;
          end else begin
            target_d = cmd_m;
            state_d  = SEQ_RESET_GEN;
          end
        end
      end
      SEQ_RESET_GEN: begin
        if (halt) begin
          state_d  = SEQ_IDLE;
          target_d = MODE_IDLE;
        end else if (timer_q == RST_LAST) begin
          state_d = SEQ_WAIT_RDY;
          timer_d = '0;
        end
      end
      SEQ_WAIT_RDY: begin
        if (halt) begin
          state_d  = SEQ_IDLE;
          target_d = MODE_IDLE;
        end else if (dac0_rdy) begin
          state_d = SEQ_RUN;
        end else if (timer_q == TIMER_LAST) begin
          to_set   = 1'b1;
          state_d  = SEQ_IDLE;
          target_d = MODE_IDLE;
        end
      end
      SEQ_RUN: begin
        timer_d = '0;
        quiet_d = '0;
        if (halt) begin
          target_d = MODE_IDLE;
          state_d  = SEQ_DRAIN;
        end else if (accept && cmd_m != target_q) begin
          if (cmd_m == MODE_PWL && !pwl_loaded) begin
            pwl_set = 1'b1;
          end else begin
            target_d = cmd_m;
            state_d  = SEQ_DRAIN;
          end
        end
      end
      SEQ_DRAIN: begin
        if (halt) target_d = MODE_IDLE;
        quiet_d = gen_batch_valid ? '0 : sat_inc(quiet_q);
        // A completed drain takes precedence over a timeout on the same cycle.
        if (!gen_batch_valid && quiet_q == QUIET_LAST) begin
          state_d = (target_d == MODE_IDLE) ? SEQ_IDLE : SEQ_RESET_GEN;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          to_set   = 1'b1;
          state_d  = SEQ_IDLE;
          target_d = MODE_IDLE;
        end
      end
      default: begin
        state_d  = SEQ_IDLE;
        target_d = MODE_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies
    // track the held state with no extra cycle of lag.
    run_d = '0;
    if (state_d == SEQ_RUN) begin
      unique case (target_d)
        MODE_SHIFT: run_d[0] = 1'b1;
        MODE_TRIG:  run_d[1] = 1'b1;
        MODE_PWL:   run_d[2] = 1'b1;
        default:    run_d    = '0;
      endcase
    end
    gen_rst_d  = (state_d == SEQ_RESET_GEN);
    cur_mode_d = (state_d == SEQ_RUN) ? target_d : MODE_IDLE;
    ready_d    = (state_d == SEQ_IDLE || state_d == SEQ_RUN) && !halt;
    err_pwl_d  = pwl_set | (err_pwl_q & ~err_clear);
    err_to_d   = to_set  | (err_to_q  & ~err_clear);
  end

  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      state_q    <= SEQ_IDLE;
      target_q   <= MODE_IDLE;
      timer_q    <= '0;
      quiet_q    <= '0;
      run_q      <= '0;
      gen_rst_q  <= 1'b0;
      cur_mode_q <= MODE_IDLE;
      ready_q    <= 1'b0;
      err_pwl_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      timer_q    <= timer_d;
      quiet_q    <= quiet_d;
      run_q      <= run_d;
      gen_rst_q  <= gen_rst_d;
      cur_mode_q <= cur_mode_d;
      ready_q    <= ready_d;
      err_pwl_q  <= err_pwl_d;
      err_to_q   <= err_to_d;
    end
  end

  assign cmd_ready      = ready_q;
  assign run_shift_regs = run_q[0];
  assign run_trig_wav   = run_q[1];
  assign run_pwl        = run_q[2];
  assign gen_rst        = gen_rst_q;
  assign cur_mode       = cur_mode_q;
  assign seq_state      = state_q;
  assign err_pwl_empty  = err_pwl_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_dac_mode_sequencer.sv
// Bench for dac_mode_sequencer: directed scenarios followed by random
// stimulus, all outputs compared every cycle against a phase/countdown
// reference model of the mode sequencing rules.
module tb_dac_mode_sequencer;
  import mem_layout_pkg::*;

  localparam int DRAIN = 8;
  localparam int RSTC  = 4;
  localparam int TMO   = 1024;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] cmd_mode = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       halt = 1'b0;
  logic       dac0_rdy = 1'b0;
  logic       pwl_loaded = 1'b0;
  logic       gbv = 1'b0;
  logic       err_clear = 1'b0;
  logic       run_shift_regs, run_trig_wav, run_pwl, gen_rst;
  logic [1:0] cur_mode;
  logic [2:0] seq_state;
  logic       err_pwl_empty, err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dac_mode_sequencer #(
    .DRAIN_CYCLES(DRAIN),
    .RST_CYCLES  (RSTC),
    .TIMEOUT     (TMO)
  ) dut (
    .dac_clk        (clk),
    .dac_rstn       (rstn),
    .cmd_mode       (cmd_mode),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .halt           (halt),
    .dac0_rdy       (dac0_rdy),
    .pwl_loaded     (pwl_loaded),
    .gen_batch_valid(gbv),
    .err_clear      (err_clear),
    .run_shift_regs (run_shift_regs),
    .run_trig_wav   (run_trig_wav),
    .run_pwl        (run_pwl),
    .gen_rst        (gen_rst),
    .cur_mode       (cur_mode),
    .seq_state      (seq_state),
    .err_pwl_empty  (err_pwl_empty),
    .err_timeout    (err_timeout)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase, target mode, cycles left in reset,
  // cycles spent waiting/draining, and length of the current quiet run.
  dac_seq_state_t m_phase;
  int m_target, m_left, m_spent, m_quiet;
  bit m_ready, m_perr, m_terr;

  task automatic mdl_reset();
    m_phase = SEQ_IDLE; m_target = 0; m_left = 0; m_spent = 0; m_quiet = 0;
    m_ready = 0; m_perr = 0; m_terr = 0;
  endtask

  task automatic mdl_step();
    bit acc, pset, tset;
    int req;
    acc  = cmd_valid && m_ready && !halt;
    req  = int'(cmd_mode);
    pset = 0; tset = 0;
    case (m_phase)
      SEQ_IDLE:
        if (acc && req != 0) begin
          if (req == 3 && !pwl_loaded) pset = 1;
          else begin m_target = req; m_phase = SEQ_RESET_GEN; m_left = RSTC; end
        end
      SEQ_RESET_GEN:
        if (halt) m_phase = SEQ_IDLE;
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = SEQ_WAIT_RDY; m_spent = 0; end
        end
      SEQ_WAIT_RDY:
        if (halt) m_phase = SEQ_IDLE;
        else if (dac0_rdy) m_phase = SEQ_RUN;
        else begin
          m_spent++;
          if (m_spent == TMO) begin tset = 1; m_phase = SEQ_IDLE; end
        end
      SEQ_RUN:
        if (halt) begin
          m_target = 0; m_phase = SEQ_DRAIN; m_quiet = 0; m_spent = 0;
        end else if (acc && req != m_target) begin
          if (req == 3 && !pwl_loaded) pset = 1;
          else begin m_target = req; m_phase = SEQ_DRAIN; m_quiet = 0; m_spent = 0; end
        end
      SEQ_DRAIN: begin
        if (halt) m_target = 0;
        m_quiet = gbv ? 0 : m_quiet + 1;
        m_spent++;
        if (m_quiet == DRAIN) begin
          m_phase = (m_target == 0) ? SEQ_IDLE : SEQ_RESET_GEN;
          m_left  = RSTC;
        end else if (m_spent == TMO) begin
          tset = 1; m_phase = SEQ_IDLE;
        end
      end
      default: m_phase = SEQ_IDLE;
    endcase
    m_perr  = pset ? 1'b1 : (err_clear ? 1'b0 : m_perr);
    m_terr  = tset ? 1'b1 : (err_clear ? 1'b0 : m_terr);
    m_ready = (m_phase == SEQ_IDLE || m_phase == SEQ_RUN) && !halt;
  endtask

  task automatic compare_all();
    int er, exp_run;
    er = (m_phase == SEQ_RUN) ? m_target : 0;
    exp_run = (er == 0) ? 0 : (1 << (er - 1));
    check("run", int'({run_pwl, run_trig_wav, run_shift_regs}), exp_run);
    check("gen_rst", int'(gen_rst), int'(m_phase == SEQ_RESET_GEN));
    check("cur_mode", int'(cur_mode), er);
    check("seq_state", int'(seq_state), int'(m_phase));
    check("cmd_ready", int'(cmd_ready), int'(m_ready));
    check("err_pwl_empty", int'(err_pwl_empty), int'(m_perr));
    check("err_timeout", int'(err_timeout), int'(m_terr));
  endtask

  // One clock: model consumes the inputs seen at the edge, DUT sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    if (rstn) mdl_step();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input int mode);
    cmd_mode  = 2'(mode);
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
  endtask

  task automatic async_reset();
    rstn = 1'b0;
    #1;
    mdl_reset();
    compare_all();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wait;
    bit any_run;
    mdl_reset();
    #12;
    compare_all();
    #10 rstn = 1'b1;
    dac0_rdy   = 1'b1;
    pwl_loaded = 1'b1;

    // cmd_ready rises on the first edge after release.
    cycle();
    check("ready_after_reset", int'(cmd_ready), 1);

    // Mode entry latency: gen_rst for t+1..t+4, run from t+6.
    send(1);
    check("t1_rst_k1", int'(gen_rst), 1);
    for (int k = 2; k <= 6; k++) begin
      cycle();
      check("t1_rst", int'(gen_rst), int'(k <= RSTC));
      check("t1_run", int'(run_shift_regs), int'(k == RSTC + 2));
    end
    check("t1_cur_mode", int'(cur_mode), 1);

    // Mode change with a busy pipeline: 5 valid cycles, then 8 quiet.
    gbv = 1'b1;
    send(2);
    check("t2_run_drop", int'(run_shift_regs), 0);
    check("t2_drain", int'(seq_state), int'(SEQ_DRAIN));
    cycles(5);
    gbv = 1'b0;
    for (int k = 1; k <= DRAIN; k++) begin
      cycle();
      check("t2_rst_after_quiet", int'(gen_rst), int'(k == DRAIN));
    end
    cycles(RSTC + 1);
    check("t2_run_trig", int'(run_trig_wav), 1);

    // PWL requested with an empty table, then cleared and retried.
    send(0);
    cycles(DRAIN);
    check("t3_idle", int'(seq_state), int'(SEQ_IDLE));
    pwl_loaded = 1'b0;
    send(3);
    check("t3_err_set", int'(err_pwl_empty), 1);
    check("t3_still_idle", int'(seq_state), int'(SEQ_IDLE));
    pulse_clear();
    check("t3_err_clr", int'(err_pwl_empty), 0);
    pwl_loaded = 1'b1;
    send(3);
    cycles(RSTC + 1);
    check("t3_run_pwl", int'(run_pwl), 1);

    // dac0_rdy never comes: exactly TIMEOUT cycles in WAIT_RDY.
    send(0);
    cycles(DRAIN);
    dac0_rdy = 1'b0;
    send(2);
    n_wait = 0; any_run = 0;
    for (int i = 0; i < TMO + 60; i++) begin
      cycle();
      if (seq_state == 3'(SEQ_WAIT_RDY)) n_wait++;
      if (run_shift_regs || run_trig_wav || run_pwl) any_run = 1;
    end
    check("t4_wait_cycles", n_wait, TMO);
    check("t4_err_timeout", int'(err_timeout), 1);
    check("t4_idle", int'(seq_state), int'(SEQ_IDLE));
    check("t4_no_run", int'(any_run), 0);
    pulse_clear();
    dac0_rdy = 1'b1;

    // halt beats a simultaneous command and holds cmd_ready low.
    send(2);
    cycles(RSTC + 1);
    check("t5_run_trig", int'(run_trig_wav), 1);
    halt = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'd1;
    cycle();
    check("t5_drain", int'(seq_state), int'(SEQ_DRAIN));
    check("t5_ready_low", int'(cmd_ready), 0);
    for (int k = 1; k <= DRAIN; k++) begin
      cycle();
      check("t5_ready_held", int'(cmd_ready), 0);
    end
    check("t5_idle", int'(seq_state), int'(SEQ_IDLE));
    cmd_valid = 1'b0; halt = 1'b0;
    cycle();
    check("t5_ready_back", int'(cmd_ready), 1);

    // Asynchronous reset in the middle of RESET_GEN.
    send(1);
    cycle();
    async_reset();
    check("t6_gen_rst_clr", int'(gen_rst), 0);
    check("t6_state_clr", int'(seq_state), int'(SEQ_IDLE));
    cycle();
    send(2);
    cycles(RSTC + 1);
    check("t6_run_trig", int'(run_trig_wav), 1);

    // Pipeline never empties: DRAIN times out.
    gbv = 1'b1;
    send(1);
    cycles(TMO + 10);
    check("t7_err_timeout", int'(err_timeout), 1);
    check("t7_idle", int'(seq_state), int'(SEQ_IDLE));
    gbv = 1'b0;
    pulse_clear();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cmd_valid  = ($urandom_range(0, 99) < 40);
      cmd_mode   = 2'($urandom_range(0, 3));
      halt       = ($urandom_range(0, 99) < 3);
      dac0_rdy   = ($urandom_range(0, 99) < 85);
      pwl_loaded = ($urandom_range(0, 99) < 80);
      gbv        = ($urandom_range(0, 99) < 15);
      err_clear  = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 999) < 3) async_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
